// File: rtl/core_types_pkg.sv
// Shared core types: ROB sizing and the branch notification sent from the BRUs to the ROB.
package core_types_pkg;

  localparam int ROB_ENTRIES         = 64;
  localparam int LOG_ROB_ENTRIES     = $clog2(ROB_ENTRIES);
  localparam int BTB_PRED_INFO_WIDTH = 8;
  localparam int PC_WIDTH            = 32;

  typedef struct packed {
    logic [LOG_ROB_ENTRIES-1:0]     ROB_index;
    logic                           is_mispredict;
    logic                           is_taken;
    logic                           use_upct;
    logic [BTB_PRED_INFO_WIDTH-1:0] updated_pred_info;
    logic                           pred_lru;
    logic [PC_WIDTH-1:0]            start_PC;
    logic [PC_WIDTH-1:0]            target_PC;
  } branch_notif_t;

  // Distance from the ROB head; the natural wrap of the index width gives the modulo.
  function automatic logic [LOG_ROB_ENTRIES-1:0] rob_age(
    input logic [LOG_ROB_ENTRIES-1:0] index,
    input logic [LOG_ROB_ENTRIES-1:0] head
  );
    return index - head;
  endfunction

endpackage

// File: rtl/branch_notif_oldest_select.sv
// Combinational oldest-first picker: one-hot grant to the valid requester closest to the ROB head.
module branch_notif_oldest_select
  import core_types_pkg::*;
#(
  parameter int REQ_COUNT = 2
) (
  input  logic [REQ_COUNT-1:0]       valid,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_index [REQ_COUNT],
  input  logic [LOG_ROB_ENTRIES-1:0] head_index,
  output logic [REQ_COUNT-1:0]       grant
);

  logic [LOG_ROB_ENTRIES-1:0] age [REQ_COUNT];

  generate
    for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_age
      assign age[gi] = rob_age(rob_index[gi], head_index);
    end
  endgenerate

  // A requester wins unless some other valid requester is strictly older, or equally old at a lower index.
  always_comb begin
    grant = '0;
    for (int j = 0; j < REQ_COUNT; j++) begin
      grant[j] = valid[j];
      for (int k = 0; k < REQ_COUNT; k++) begin
        if (k != j && valid[k]) begin
          if ((age[k] < age[j]) || ((age[k] == age[j]) && (k < j))) begin
            grant[j] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bru_branch_notif_arbiter.sv
// Arbitrates BRU branch notifications onto the single ROB port through a one-entry output stage.
// BRU_NOTIF_ARB_AGE_PRIORITY_EN selects oldest-first grant; otherwise round-robin.
module bru_branch_notif_arbiter
  import core_types_pkg::*;
#(
  parameter int BRU_COUNT = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_head_index,
  input  logic [BRU_COUNT-1:0]       req_valid,
  input  branch_notif_t              req_notif [BRU_COUNT],
  output logic [BRU_COUNT-1:0]       req_ready,
  output logic                       branch_notif_valid,
  output branch_notif_t              branch_notif,
  input  logic                       branch_notif_ready,
  output logic [15:0]                mispredict_sent_count
);

  localparam int IDX_W = $clog2(BRU_COUNT);

  logic [BRU_COUNT-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 out_free;
  logic                 accept;
  branch_notif_t        sel_notif;

`ifdef BRU_NOTIF_ARB_AGE_PRIORITY_EN
  logic [LOG_ROB_ENTRIES-1:0] req_index [BRU_COUNT];

  generate
    for (genvar gi = 0; gi < BRU_COUNT; gi++) begin : g_index
      assign req_index[gi] = req_notif[gi].ROB_index;
    end
  endgenerate

  branch_notif_oldest_select #(
    .REQ_COUNT (BRU_COUNT)
  ) u_oldest_select (
    .valid      (req_valid),
    .rob_index  (req_index),
    .head_index (rob_head_index),
    .grant      (grant)
  );
`else
  logic [IDX_W-1:0] rr_ptr_reg;
  logic             unused_head;

  assign unused_head = ^rob_head_index;

  // First valid requester at or after ptr, wrapping around.
  function automatic logic [BRU_COUNT-1:0] rr_pick(
    input logic [BRU_COUNT-1:0] valid,
    input logic [IDX_W-1:0]     ptr
  );
    logic [BRU_COUNT-1:0] g;
    logic                 found;
    int                   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < BRU_COUNT; k++) begin
      idx = (int'(ptr) + k) % BRU_COUNT;
      if (!found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  assign grant = rr_pick(req_valid, rr_ptr_reg);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_reg <= '0;
    end else if (accept) begin
      rr_ptr_reg <= (grant_idx == IDX_W'(BRU_COUNT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  assign out_free = ~branch_notif_valid | branch_notif_ready;

  generate
    for (genvar gi = 0; gi < BRU_COUNT; gi++) begin : g_ready
      assign req_ready[gi] = grant[gi] & out_free;
    end
  endgenerate

  assign accept = |(req_valid & req_ready);

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < BRU_COUNT; j++) begin
      if (grant[j]) begin
        grant_idx = j[IDX_W-1:0];
      end
    end
  end

  assign sel_notif = req_notif[grant_idx];

  // A drain and a new accept in the same cycle simply replace the entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_notif_valid <= 1'b0;
      branch_notif       <= '0;
    end else if (accept) begin
      branch_notif_valid <= 1'b1;
      branch_notif       <= sel_notif;
    end else if (branch_notif_ready) begin
      branch_notif_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispredict_sent_count <= '0;
    end else if (branch_notif_valid && branch_notif_ready && branch_notif.is_mispredict
                 && (mispredict_sent_count != 16'hFFFF)) begin
      mispredict_sent_count <= mispredict_sent_count + 16'd1;
    end
  end

endmodule
